// File: rtl/gate_seq.sv
// gate_seq: steps through a gate list and evaluates one gate at a time.
// For each gate it fetches the input labels from the label controller,
// optionally runs the AND evaluator, and writes the output label back.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   start, gate_count        begin a run of gate_count gates
//   gate_addr, gate_rd_en    gate list read port (data back one cycle later)
//   gate_data                {type, in1, in2, out}
//   wire_id_read, id_1_strobe, id_2_strobe, gate_type,
//   wire_id_write, store_strobe, label_store      requests to label controller
//   lc_done, lc_label, lc_point                   label controller responses
//   and_req, and_plaintext, and_point, and_gate_idx  AND evaluator request
//   and_valid, and_result                         AND evaluator response
//   busy, done, err          status (done is a one-cycle pulse, err sticky)
//
// Build option: GATE_SEQ_WDT_EN adds a wait-state watchdog that parks the
// block in FAULT with err=1. Without it err is tied low and waits are unbounded.
//
// state    | meaning
// IDLE     | waiting for start
// RD_GATE  | read port strobed at the current index
// LATCH    | gate descriptor registered
// ISSUE_1  | fetch label of in1
// WAIT_1   | wait for lc_done of in1 fetch
// ISSUE_2  | fetch label of in2
// WAIT_2   | wait for lc_done of in2 fetch
// AND_REQ  | request AND evaluation
// AND_WAIT | wait for and_valid
// ISSUE_ST | store the output label
// WAIT_ST  | wait for lc_done of the store
// NEXT     | advance index, finish when all gates are done
// FAULT    | watchdog expired, left only by rst

module gate_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [12:0]  gate_count,
  output logic [12:0]  gate_addr,
  output logic         gate_rd_en,
  input  logic [40:0]  gate_data,
  output logic [12:0]  wire_id_read,
  output logic         id_1_strobe,
  output logic         id_2_strobe,
  output logic [1:0]   gate_type,
  output logic [12:0]  wire_id_write,
  output logic         store_strobe,
  output logic [127:0] label_store,
  input  logic         lc_done,
  input  logic [127:0] lc_label,
  input  logic [1:0]   lc_point,
  output logic         and_req,
  output logic [127:0] and_plaintext,
  output logic [1:0]   and_point,
  output logic [12:0]  and_gate_idx,
  input  logic         and_valid,
  input  logic [127:0] and_result,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [3:0] {
    IDLE, RD_GATE, LATCH, ISSUE_1, WAIT_1, ISSUE_2, WAIT_2,
    AND_REQ, AND_WAIT, ISSUE_ST, WAIT_ST, NEXT, FAULT
  } state_t;

  localparam logic [1:0] T_AND = 2'd0;

  state_t      state, state_n;
  logic [12:0] idx, cnt;
  logic [12:0] g_in1, g_in2, g_out;
  logic [1:0]  g_type;
  logic        last;

  // widened compare so gate_count=8191 terminates without index wrap
  assign last = ({1'b0, idx} + 14'd1) == {1'b0, cnt};

`ifdef GATE_SEQ_WDT_EN
  logic [7:0] wdt;
  logic       err_q;
  logic       in_wait;
  logic       wdt_tc;

  assign in_wait = (state == WAIT_1) || (state == WAIT_2) ||
                   (state == AND_WAIT) || (state == WAIT_ST);
  // down-counter from 255: terminal count after 255 cycles in one wait state
  assign wdt_tc  = in_wait && (wdt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt   <= 8'hFF;
      err_q <= 1'b0;
    end else begin
      if (state_n != state)
        wdt <= 8'hFF;
      else if (in_wait && wdt != 8'd0)
        wdt <= wdt - 8'd1;
      if (wdt_tc)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start && gate_count != 13'd0) state_n = RD_GATE;
      RD_GATE:  state_n = LATCH;
      LATCH:    state_n = ISSUE_1;
      ISSUE_1:  state_n = WAIT_1;
      WAIT_1:   if (lc_done) state_n = g_type[1] ? ISSUE_ST : ISSUE_2;
      ISSUE_2:  state_n = WAIT_2;
      WAIT_2:   if (lc_done) state_n = (g_type == T_AND) ? AND_REQ : ISSUE_ST;
      AND_REQ:  state_n = AND_WAIT;
      AND_WAIT: if (and_valid) state_n = ISSUE_ST;
      ISSUE_ST: state_n = WAIT_ST;
      WAIT_ST:  if (lc_done) state_n = NEXT;
      NEXT:     state_n = last ? IDLE : RD_GATE;
      FAULT:    state_n = FAULT;
      default:  state_n = IDLE;
    endcase
`ifdef GATE_SEQ_WDT_EN
    if (wdt_tc) state_n = FAULT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      cnt           <= '0;
      g_type        <= '0;
      g_in1         <= '0;
      g_in2         <= '0;
      g_out         <= '0;
      label_store   <= '0;
      and_plaintext <= '0;
      and_point     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idx  <= '0;
          cnt  <= gate_count;
          busy <= (gate_count != 13'd0);
          done <= (gate_count == 13'd0);
        end
        LATCH: {g_type, g_in1, g_in2, g_out} <= gate_data;
        WAIT_1: if (lc_done && g_type[1]) label_store <= lc_label;
        WAIT_2: if (lc_done) begin
          if (g_type == T_AND) begin
            and_plaintext <= lc_label;
            and_point     <= lc_point;
          end else begin
            label_store <= lc_label;
          end
        end
        AND_WAIT: if (and_valid) label_store <= and_result;
        NEXT: begin
          idx <= idx + 13'd1;
          if (last) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
      if (state_n == FAULT) busy <= 1'b0;
    end
  end

  always_comb begin
    gate_rd_en    = (state == RD_GATE);
    gate_addr     = idx;
    id_1_strobe   = (state == ISSUE_1);
    id_2_strobe   = (state == ISSUE_2);
    store_strobe  = (state == ISSUE_ST);
    and_req       = (state == AND_REQ);
    and_gate_idx  = idx;
    gate_type     = g_type;
    wire_id_write = g_out;
    wire_id_read  = ((state == ISSUE_2) || (state == WAIT_2)) ? g_in2 : g_in1;
  end

endmodule

// File: tb/tb_gate_seq.sv
module tb_gate_seq;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [12:0]  gate_count, gate_addr;
  logic         gate_rd_en;
  logic [40:0]  gate_data;
  logic [12:0]  wire_id_read, wire_id_write, and_gate_idx;
  logic         id_1_strobe, id_2_strobe, store_strobe;
  logic [1:0]   gate_type, lc_point, and_point;
  logic [127:0] label_store, lc_label, and_plaintext, and_result;
  logic         lc_done, and_req, and_valid, busy, done, err;

  always #5 clk = ~clk;

  gate_seq dut (
    .clk(clk), .rst(rst), .start(start), .gate_count(gate_count),
    .gate_addr(gate_addr), .gate_rd_en(gate_rd_en), .gate_data(gate_data),
    .wire_id_read(wire_id_read), .id_1_strobe(id_1_strobe), .id_2_strobe(id_2_strobe),
    .gate_type(gate_type), .wire_id_write(wire_id_write), .store_strobe(store_strobe),
    .label_store(label_store), .lc_done(lc_done), .lc_label(lc_label), .lc_point(lc_point),
    .and_req(and_req), .and_plaintext(and_plaintext), .and_point(and_point),
    .and_gate_idx(and_gate_idx), .and_valid(and_valid), .and_result(and_result),
    .busy(busy), .done(done), .err(err)
  );

  logic [40:0]  gate_mem [0:63];
  logic [127:0] wire_mem [0:63];
  logic [1:0]   pt_mem   [0:63];
  logic [127:0] ref_mem  [0:63];

  logic [12:0]  q_addr[$], q_rd[$], q_st_id[$], q_and_idx[$];
  logic [1:0]   q_type[$], q_and_pt[$];
  logic [127:0] q_st_lab[$], q_and_pl[$];
  int e_id2, e_and;

  int n_chk = 0, n_pass = 0;
  logic mon_en = 1'b0, noise = 1'b0, lc_hold = 1'b0, and_fixed = 1'b0;
  int done_cnt = 0, n_id1 = 0, n_id2 = 0, n_st = 0, n_and = 0, any_stb = 0;

  int lc_pend = 0, lc_cnt = 0, and_pend = 0, and_cnt = 0;
  logic [127:0] rd_lab, cap_lab, and_res_q;
  logic [1:0]   rd_pt;
  logic [12:0]  cap_id;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [40:0] rnd41();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[40:0];
  endfunction

  // AND evaluator behaviour shared by the responder and the reference model
  function automatic logic [127:0] and_fn(input logic [127:0] pl, input logic [1:0] pt,
                                          input logic [12:0] gi);
    if (and_fixed) return 128'h1234;
    return {pl[126:0], pl[127]} ^ {113'd0, pt, gi};
  endfunction

  // Gate memory: data appears the cycle after gate_rd_en, garbage otherwise
  always @(posedge clk) begin
    if (gate_rd_en) gate_data <= gate_mem[gate_addr[5:0]];
    else            gate_data <= rnd41();
  end

  // Monitor plus label-controller and AND-evaluator responders
  always @(negedge clk) begin
    int nst;
    nst = int'(id_1_strobe) + int'(id_2_strobe) + int'(store_strobe) + int'(and_req);
    any_stb += nst;
    if (rst) begin
      lc_pend = 0; and_pend = 0; lc_done = 1'b0; and_valid = 1'b0;
      lc_label = '0; lc_point = '0; and_result = '0;
    end else begin
      if (mon_en) begin
        if (nst > 1) check("one_strobe", 128'(nst), 128'(1));
        if (gate_rd_en) begin
          if (q_addr.size() == 0) check("addr_extra", 128'(1), 128'(0));
          else check("gate_addr", 128'(gate_addr), 128'(q_addr.pop_front()));
        end
        if (id_1_strobe) begin
          n_id1++;
          if (q_rd.size() == 0) check("id1_extra", 128'(1), 128'(0));
          else check("id1_wire", 128'(wire_id_read), 128'(q_rd.pop_front()));
          if (q_type.size() == 0) check("type_extra", 128'(1), 128'(0));
          else check("gate_type", 128'(gate_type), 128'(q_type.pop_front()));
        end
        if (id_2_strobe) begin
          n_id2++;
          if (q_rd.size() == 0) check("id2_extra", 128'(1), 128'(0));
          else check("id2_wire", 128'(wire_id_read), 128'(q_rd.pop_front()));
        end
        if (store_strobe) begin
          n_st++;
          if (q_st_id.size() == 0) check("store_extra", 128'(1), 128'(0));
          else begin
            check("store_id", 128'(wire_id_write), 128'(q_st_id.pop_front()));
            check("store_label", label_store, q_st_lab.pop_front());
          end
        end
        if (and_req) begin
          n_and++;
          if (q_and_idx.size() == 0) check("and_extra", 128'(1), 128'(0));
          else begin
            check("and_point", 128'(and_point), 128'(q_and_pt.pop_front()));
            check("and_gate_idx", 128'(and_gate_idx), 128'(q_and_idx.pop_front()));
            check("and_plaintext", and_plaintext, q_and_pl.pop_front());
          end
        end
        if (done) done_cnt++;
      end

      lc_done  = 1'b0;
      lc_label = rnd128();
      lc_point = 2'($urandom_range(0, 3));
      if (id_1_strobe || id_2_strobe || store_strobe) begin
        if (lc_pend != 0) check("lc_overlap", 128'(1), 128'(0));
        lc_cnt = $urandom_range(1, 5);
        if (store_strobe) begin
          lc_pend = 2;
          cap_id  = wire_id_write;
          cap_lab = label_store;
          wire_mem[cap_id[5:0]] = cap_lab;
        end else begin
          lc_pend = 1;
          rd_lab  = wire_mem[wire_id_read[5:0]];
          rd_pt   = pt_mem[wire_id_read[5:0]];
        end
      end else if (lc_pend != 0) begin
        if (!lc_hold) lc_cnt--;
        if (lc_cnt == 0) begin
          lc_done = 1'b1;
          if (lc_pend == 1) begin
            lc_label = rd_lab;
            lc_point = rd_pt;
          end else begin
            check("store_id_stable", 128'(wire_id_write), 128'(cap_id));
            check("store_label_stable", label_store, cap_lab);
          end
          lc_pend = 0;
        end
      end else if (noise && $urandom_range(0, 7) == 0) begin
        lc_done = 1'b1;
      end

      and_valid  = 1'b0;
      and_result = rnd128();
      if (and_req) begin
        if (and_pend != 0) check("and_overlap", 128'(1), 128'(0));
        and_pend  = 1;
        and_cnt   = $urandom_range(1, 6);
        and_res_q = and_fn(and_plaintext, and_point, and_gate_idx);
      end else if (and_pend != 0) begin
        and_cnt--;
        if (and_cnt == 0) begin
          and_valid  = 1'b1;
          and_result = and_res_q;
          and_pend   = 0;
        end
      end else if (noise && $urandom_range(0, 7) == 0) begin
        and_valid = 1'b1;
      end
    end
  end

  // Reference model: evaluate the gate list in order on an abstract wire store
  task automatic build_model(input int n);
    logic [40:0]  g;
    logic [1:0]   t;
    logic [12:0]  a, b, o;
    logic [127:0] lab;
    q_addr.delete(); q_rd.delete(); q_type.delete(); q_st_id.delete();
    q_st_lab.delete(); q_and_pt.delete(); q_and_idx.delete(); q_and_pl.delete();
    e_id2 = 0; e_and = 0;
    for (int k = 0; k < 64; k++) ref_mem[k] = wire_mem[k];
    for (int i = 0; i < n; i++) begin
      g = gate_mem[i];
      t = g[40:39]; a = g[38:26]; b = g[25:13]; o = g[12:0];
      q_addr.push_back(13'(i));
      q_type.push_back(t);
      q_rd.push_back(a);
      if (t == 2'd2 || t == 2'd3) begin
        lab = ref_mem[a[5:0]];
      end else begin
        e_id2++;
        q_rd.push_back(b);
        if (t == 2'd1) lab = ref_mem[b[5:0]];
        else begin
          e_and++;
          q_and_pl.push_back(ref_mem[b[5:0]]);
          q_and_pt.push_back(pt_mem[b[5:0]]);
          q_and_idx.push_back(13'(i));
          lab = and_fn(ref_mem[b[5:0]], pt_mem[b[5:0]], 13'(i));
        end
      end
      ref_mem[o[5:0]] = lab;
      q_st_id.push_back(o);
      q_st_lab.push_back(lab);
    end
  endtask

  task automatic run_gates(input int n, input logic poke);
    int cyc, b_done, b1, b2, bst, band;
    build_model(n);
    mon_en = 1'b1;
    b_done = done_cnt; b1 = n_id1; b2 = n_id2; bst = n_st; band = n_and;
    @(negedge clk); start = 1'b1; gate_count = 13'(n);
    @(negedge clk); start = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; gate_count = 13'd5;
      @(negedge clk); start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!done) begin
      check("timeout", 128'(1), 128'(0));
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
    @(negedge clk);
    check("done_width", 128'(done), 128'(0));
    check("done_once", 128'(done_cnt - b_done), 128'(1));
    check("busy_end", 128'(busy), 128'(0));
    check("err_low", 128'(err), 128'(0));
    check("n_id1", 128'(n_id1 - b1), 128'(n));
    check("n_id2", 128'(n_id2 - b2), 128'(e_id2));
    check("n_store", 128'(n_st - bst), 128'(n));
    check("n_and", 128'(n_and - band), 128'(e_and));
    check("left_stores", 128'(q_st_id.size() + q_addr.size() + q_rd.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] saved, aa;
    int base, n;
    rst = 1'b1; start = 1'b0; gate_count = '0;
    lc_done = 1'b0; lc_label = '0; lc_point = '0; and_valid = 1'b0; and_result = '0;
    for (int k = 0; k < 64; k++) begin
      wire_mem[k] = rnd128();
      pt_mem[k]   = 2'($urandom_range(0, 3));
      gate_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_strobes", 128'({gate_rd_en, id_1_strobe, id_2_strobe, store_strobe, and_req}), 128'(0));
    check("rst_ids", 128'({gate_addr, wire_id_read, wire_id_write, and_gate_idx}), 128'(0));
    check("rst_labels", label_store | and_plaintext, 128'(0));
    check("rst_points", 128'({and_point, gate_type}), 128'(0));
    rst = 1'b0;

    // single BUF {2,5,0,9}
    saved = wire_mem[5];
    gate_mem[0] = {2'd2, 13'd5, 13'd0, 13'd9};
    run_gates(1, 1'b0);
    check("buf_wire9", wire_mem[9], saved);

    // XOR {1,3,4,7}, second fetch returns 0xAA..A
    aa = {32{4'hA}};
    wire_mem[4] = aa;
    gate_mem[0] = {2'd1, 13'd3, 13'd4, 13'd7};
    run_gates(1, 1'b0);
    check("xor_wire7", wire_mem[7], aa);

    // AND {0,1,2,6}, point 2'b10, result 0x1234
    pt_mem[2] = 2'b10;
    and_fixed = 1'b1;
    gate_mem[0] = {2'd0, 13'd1, 13'd2, 13'd6};
    run_gates(1, 1'b0);
    check("and_wire6", wire_mem[6], 128'h1234);
    and_fixed = 1'b0;

    // BUF, XOR, AND with random latency, spurious responses and a start while busy
    noise = 1'b1;
    gate_mem[0] = {2'd2, 13'd10, 13'd11, 13'd12};
    gate_mem[1] = {2'd1, 13'd12, 13'd13, 13'd14};
    gate_mem[2] = {2'd0, 13'd14, 13'd12, 13'd15};
    run_gates(3, 1'b1);

    // gate_count = 0
    base = any_stb;
    @(negedge clk); start = 1'b1; gate_count = 13'd0;
    @(negedge clk); start = 1'b0;
    check("zero_done", 128'(done), 128'(1));
    @(negedge clk);
    check("zero_done_end", 128'(done), 128'(0));
    repeat (5) @(negedge clk);
    check("zero_strobes", 128'(any_stb - base), 128'(0));

    // random gate lists, INV included
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      noise = r[0];
      for (int i = 0; i < n; i++)
        gate_mem[i] = {2'($urandom_range(0, 3)), 13'($urandom_range(0, 63)),
                       13'($urandom_range(0, 63)), 13'($urandom_range(0, 63))};
      run_gates(n, 1'b0);
    end
    noise = 1'b0;

    // reset mid-gate aborts with no further strobes
    mon_en = 1'b0;
    @(negedge clk); start = 1'b1; gate_count = 13'd6;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = any_stb;
    repeat (30) @(negedge clk);
    check("abort_strobes", 128'(any_stb - base), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_addr", 128'(gate_addr), 128'(0));

`ifdef GATE_SEQ_WDT_EN
    begin
      int k;
      gate_mem[0] = {2'd2, 13'd1, 13'd0, 13'd2};
      lc_hold = 1'b1;
      @(negedge clk); start = 1'b1; gate_count = 13'd1;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!id_1_strobe && k < 20) begin @(negedge clk); k++; end
      check("wdt_issue1", 128'(id_1_strobe), 128'(1));
      repeat (256) @(negedge clk);
      check("wdt_early", 128'(err), 128'(0));
      @(negedge clk);
      check("wdt_err", 128'(err), 128'(1));
      check("wdt_busy", 128'(busy), 128'(0));
      @(negedge clk); start = 1'b1; gate_count = 13'd1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("wdt_sticky", 128'(err), 128'(1));
      check("wdt_no_read", 128'(gate_rd_en), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lc_hold = 1'b0;
      check("wdt_rst_clear", 128'(err), 128'(0));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
